tag_lookup_ctrl: RTL and testbench

//  Cache tag-lookup controller that sits directly upstream of the synchronous-read tag RAM (ram_sync_read_t1).
//  - Accepts CPU lookup requests, drives the RAM index, compares the returned tag and reports hit/miss.
//  - On a miss, requests a line fill from the memory side; on acknowledge, writes the new valid tag into the RAM.
//  - Tag RAM entry format: {valid[DWIDTH-1], tag[DWIDTH-2:0]}.

---
 rtl/tag_lookup_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// tag_lookup_ctrl
//   Cache tag-lookup controller placed directly in front of a synchronous-read
//   tag RAM. A CPU lookup drives the RAM index on the accept edge, the returned
//   entry {valid, tag} is compared in the following cycle, and a hit/miss
//   response is pulsed. A miss raises a fill request toward memory; once it is
//   acknowledged the new valid tag is written back into the RAM and a miss
//   response is pulsed.
//
// Optional feature macro: TAG_INVALIDATE_EN
//   When defined, adds inv_valid/inv_index. An invalidate seen in IDLE clears
//   the addressed entry and wins over a simultaneous lookup request.
//
// Ports
//   clock       rising-edge clock, shared with the tag RAM
//   reset       synchronous active-high reset
//   req_valid   lookup request valid
//   req_ready   request accepted when req_valid & req_ready at a posedge
//   req_addr    {tag, index, offset}
//   resp_valid  one-cycle response pulse
//   resp_hit    1 = hit, 0 = miss (after fill); qualified by resp_valid
//   resp_index  index of the responded request
//   miss_valid  fill request, held until miss_ack
//   miss_addr   latched request address with offset cleared
//   miss_ack    fill complete, only honoured while waiting for a fill
//   ram_addr    tag RAM address
//   ram_we      tag RAM write enable
//   ram_din     tag RAM write data
//   ram_dout    tag RAM read data, valid the cycle after the address edge
//   inv_valid   (TAG_INVALIDATE_EN) invalidate request
//   inv_index   (TAG_INVALIDATE_EN) index to invalidate
// -----------------------------------------------------------------------------
module tag_lookup_ctrl #(
    parameter  int AWIDTH   = 3,
    parameter  int DWIDTH   = 14,
    parameter  int OFFSET_W = 2,
    localparam int TAG_W    = DWIDTH - 1,
    localparam int REQ_W    = DWIDTH - 1 + AWIDTH + OFFSET_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REQ_W-1:0]  req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [AWIDTH-1:0] resp_index,
    output logic              miss_valid,
    output logic [REQ_W-1:0]  miss_addr,
    input  logic              miss_ack,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_we,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout
`ifdef TAG_INVALIDATE_EN
    ,
    input  logic              inv_valid,
    input  logic [AWIDTH-1:0] inv_index
`endif
);

    localparam logic [REQ_W-1:0] OFFSET_MASK = {{(REQ_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_MISS    = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [REQ_W-1:0]   addr_r;
    logic [TAG_W-1:0]   tag_r_s;
    logic [AWIDTH-1:0]  idx_r_s;
    logic [AWIDTH-1:0]  req_idx_s;
    logic               hit_s;
    logic               accept_s;
    logic               ready_s;
    logic               we_s;
    logic [AWIDTH-1:0]  addr_s;
    logic [DWIDTH-1:0]  din_s;
    logic               inv_s;
    logic [AWIDTH-1:0]  inv_idx_s;

`ifdef TAG_INVALIDATE_EN
    assign inv_s     = inv_valid;
    assign inv_idx_s = inv_index;
`else
    assign inv_s     = 1'b0;
    assign inv_idx_s = {AWIDTH{1'b0}};
`endif

    assign tag_r_s   = addr_r[REQ_W-1:AWIDTH+OFFSET_W];
    assign idx_r_s   = addr_r[AWIDTH+OFFSET_W-1:OFFSET_W];
    assign req_idx_s = req_addr[AWIDTH+OFFSET_W-1:OFFSET_W];

    // Only a valid entry whose stored tag equals the latched tag is a hit.
    assign hit_s = ram_dout[DWIDTH-1] & (ram_dout[DWIDTH-2:0] == tag_r_s);

    // Reset blocks new accepts and any RAM write in flight.
    assign req_ready = ready_s & ~reset;
    assign ram_we    = we_s & ~reset;
    assign ram_addr  = addr_s;
    assign ram_din   = din_s;

    // Next-state logic and the RAM-side / handshake outputs.
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 1'b0;
        accept_s    = 1'b0;
        we_s        = 1'b0;
        addr_s      = idx_r_s;
        din_s       = {DWIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (inv_s) begin
                    // Invalidate: clear the entry, hold off the request one cycle.
                    we_s   = 1'b1;
                    addr_s = inv_idx_s;
                end else begin
                    // Index goes straight to the RAM so it is captured on the accept edge.
                    ready_s = 1'b1;
                    addr_s  = req_idx_s;
                    if (req_valid) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_COMPARE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
            end
            ST_COMPARE: begin
                if (hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MISS;
                end
            end
            ST_MISS: begin
                if (miss_ack) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_MISS;
                end
            end
            ST_WRITE: begin
                we_s        = 1'b1;
                din_s       = {1'b1, tag_r_s};
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch, response pulse and fill-request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r     <= {REQ_W{1'b0}};
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_index <= {AWIDTH{1'b0}};
            miss_valid <= 1'b0;
            miss_addr  <= {REQ_W{1'b0}};
        end else begin
            resp_valid <= 1'b0;
            if (accept_s) begin
                addr_r <= req_addr;
            end
            case (state_r)
                ST_COMPARE: begin
                    if (hit_s) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        resp_index <= idx_r_s;
                    end else begin
                        miss_valid <= 1'b1;
                        miss_addr  <= addr_r & ~OFFSET_MASK;
                    end
                end
                ST_MISS: begin
                    if (miss_ack) begin
                        miss_valid <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // Response follows the write so a request accepted now sees the new tag.
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b0;
                    resp_index <= idx_r_s;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tag_lookup_ctrl
//   Directed bench for tag_lookup_ctrl with a behavioural synchronous-read tag
//   RAM. Inputs change on the falling edge, outputs are sampled on the falling
//   edge. Define TAG_INVALIDATE_EN to also exercise the invalidate path.
// -----------------------------------------------------------------------------
module tb_tag_lookup_ctrl;

    localparam int AW = 3;
    localparam int DW = 14;
    localparam int OW = 2;
    localparam int RW = 18;
    localparam logic [12:0] TAG = 13'h052E;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [RW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_hit;
    logic [AW-1:0] resp_index;
    logic          miss_valid;
    logic [RW-1:0] miss_addr;
    logic          miss_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef TAG_INVALIDATE_EN
    logic          inv_valid;
    logic [AW-1:0] inv_index;
`endif

    // Bench-side preload port into the tag RAM model.
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_din;
    logic [DW-1:0] mem [0:7];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    tag_lookup_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_index (resp_index),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ack   (miss_ack),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
`ifdef TAG_INVALIDATE_EN
        ,
        .inv_valid  (inv_valid),
        .inv_index  (inv_index)
`endif
    );

    // Synchronous-read tag RAM, shared by the DUT and the preload port.
    always @(posedge clock) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_din;
            ram_dout      <= mem[pre_addr];
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    // Event recorder: responses and DUT RAM writes.
    int            cyc    = 0;
    int            we_cnt = 0;
    logic [AW-1:0] rq_idx [$];
    logic          rq_hit [$];
    int            rq_cyc [$];
    always @(negedge clock) begin
        cyc++;
        if (resp_valid) begin
            rq_idx.push_back(resp_index);
            rq_hit.push_back(resp_hit);
            rq_cyc.push_back(cyc);
        end
        if (ram_we) we_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_addr(input logic [12:0] t, input logic [AW-1:0] i,
                                              input logic [OW-1:0] o);
        return {t, i, o};
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_din  = d;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    // Present a request on a falling edge and step past its accept edge.
    task automatic issue(input logic [RW-1:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        check_val("issue_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Count falling edges after the accept edge until resp_valid (bounded).
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
    endtask

    // Finish an outstanding fill: ack, then step to the response cycle.
    task automatic do_fill();
        miss_ack = 1'b1;
        @(negedge clock);
        miss_ack = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int we0;
        int r0;
        int sent;
        logic acc;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = {RW{1'b0}};
        miss_ack  = 1'b0;
        pre_we    = 1'b0;
        pre_addr  = {AW{1'b0}};
        pre_din   = {DW{1'b0}};
`ifdef TAG_INVALIDATE_EN
        inv_valid = 1'b0;
        inv_index = {AW{1'b0}};
`endif
        repeat (3) @(negedge clock);

        // Reset values
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_hit",   32'(resp_hit),   32'd0);
        check_val("rst_resp_index", 32'(resp_index), 32'd0);
        check_val("rst_miss_valid", 32'(miss_valid), 32'd0);
        check_val("rst_miss_addr",  32'(miss_addr),  32'd0);
        check_val("rst_ram_we",     32'(ram_we),     32'd0);
        check_val("rst_req_ready",  32'(req_ready),  32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_val("idle_req_ready", 32'(req_ready), 32'd1);

        // Hit: entry 1 valid with matching tag
        preload(3'd1, 14'h252E);
        we0 = we_cnt;
        issue(18'h0A5C5);
        check_val("cmp_req_ready", 32'(req_ready), 32'd0);
        wait_resp(lat);
        check_val("hit_latency", 32'(lat), 32'd2);
        check_val("hit_resp_hit", 32'(resp_hit), 32'd1);
        check_val("hit_resp_index", 32'(resp_index), 32'd1);
        check_val("hit_ready_with_resp", 32'(req_ready), 32'd1);
        @(negedge clock);
        check_val("hit_pulse_width", 32'(resp_valid), 32'd0);
        check_val("hit_no_write", 32'(we_cnt - we0), 32'd0);

        // Miss on invalid entry, ack after 5 cycles, fill written
        preload(3'd1, 14'h052E);
        we0 = we_cnt;
        issue(18'h0A5C5);
        @(negedge clock);
        check_val("miss_valid", 32'(miss_valid), 32'd1);
        check_val("miss_addr", 32'(miss_addr), 32'h0A5C4);
        check_val("miss_no_resp", 32'(resp_valid), 32'd0);
        repeat (5) @(negedge clock);
        check_val("miss_held", 32'(miss_valid), 32'd1);
        check_val("miss_no_we", 32'(ram_we), 32'd0);
        miss_ack = 1'b1;
        @(negedge clock);
        miss_ack = 1'b0;
        check_val("wr_ram_we", 32'(ram_we), 32'd1);
        check_val("wr_ram_addr", 32'(ram_addr), 32'd1);
        check_val("wr_ram_din", 32'(ram_din), 32'h252E);
        check_val("wr_miss_drop", 32'(miss_valid), 32'd0);
        @(negedge clock);
        check_val("fill_resp_valid", 32'(resp_valid), 32'd1);
        check_val("fill_resp_hit", 32'(resp_hit), 32'd0);
        check_val("fill_resp_index", 32'(resp_index), 32'd1);
        check_val("fill_we_off", 32'(ram_we), 32'd0);
        check_val("fill_mem1", 32'(mem[1]), 32'h252E);
        check_val("fill_we_count", 32'(we_cnt - we0), 32'd1);
        // Back-to-back: request in the response cycle sees the written tag
        issue(18'h0A5C5);
        wait_resp(lat);
        check_val("refill_hit_lat", 32'(lat), 32'd2);
        check_val("refill_hit", 32'(resp_hit), 32'd1);
        @(negedge clock);

        // Tag mismatch at index 1
        preload(3'd1, 14'h2001);
        issue(18'h0A5C5);
        @(negedge clock);
        check_val("tagmm_miss", 32'(miss_valid), 32'd1);
        do_fill();
        check_val("tagmm_resp_valid", 32'(resp_valid), 32'd1);
        check_val("tagmm_resp_hit", 32'(resp_hit), 32'd0);
        check_val("tagmm_mem1", 32'(mem[1]), 32'h252E);
        @(negedge clock);

        // Reset while waiting for a fill
        preload(3'd2, 14'h0000);
        issue(mk_addr(TAG, 3'd2, 2'd3));
        @(negedge clock);
        check_val("rmiss_valid", 32'(miss_valid), 32'd1);
        check_val("rmiss_addr", 32'(miss_addr), 32'(mk_addr(TAG, 3'd2, 2'd0)));
        we0 = we_cnt;
        r0  = rq_idx.size();
        reset = 1'b1;
        @(negedge clock);
        check_val("rmiss_drop", 32'(miss_valid), 32'd0);
        check_val("rmiss_ready_in_rst", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_val("rmiss_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        miss_ack = 1'b1;
        @(negedge clock);
        miss_ack = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rmiss_no_write", 32'(we_cnt - we0), 32'd0);
        check_val("rmiss_no_resp", 32'(rq_idx.size() - r0), 32'd0);
        check_val("rmiss_mem2", 32'(mem[2]), 32'd0);

        // Back-to-back hits, indices 0..7 with req_valid held
        for (int i = 0; i < 8; i++) preload(3'(i), 14'h252E);
        r0   = rq_idx.size();
        sent = 0;
        req_addr  = mk_addr(TAG, 3'd0, 2'd0);
        req_valid = 1'b1;
        for (int c = 0; c < 60 && sent < 8; c++) begin
            acc = req_ready;
            @(negedge clock);
            if (acc) begin
                sent++;
                if (sent < 8) req_addr = mk_addr(TAG, sent[AW-1:0], 2'd0);
                else req_valid = 1'b0;
            end
        end
        repeat (4) @(negedge clock);
        check_val("b2b_count", 32'(rq_idx.size() - r0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (r0 + i < rq_idx.size()) begin
                check_val($sformatf("b2b_idx%0d", i), 32'(rq_idx[r0+i]), 32'(i));
                check_val($sformatf("b2b_hit%0d", i), 32'(rq_hit[r0+i]), 32'd1);
                if (i > 0)
                    check_val($sformatf("b2b_gap%0d", i), 32'(rq_cyc[r0+i] - rq_cyc[r0+i-1]), 32'd2);
            end
        end

`ifdef TAG_INVALIDATE_EN
        // Invalidate entry 1, then the lookup misses
        inv_valid = 1'b1;
        inv_index = 3'd1;
        #1;
        check_val("inv_we", 32'(ram_we), 32'd1);
        check_val("inv_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        inv_valid = 1'b0;
        check_val("inv_mem1", 32'(mem[1]), 32'd0);
        issue(18'h0A5C5);
        @(negedge clock);
        check_val("inv_miss", 32'(miss_valid), 32'd1);
        do_fill();
        @(negedge clock);
        // Invalidate and request together: invalidate first, accept next cycle
        inv_valid = 1'b1;
        inv_index = 3'd3;
        req_valid = 1'b1;
        req_addr  = 18'h0A5C5;
        #1;
        check_val("inv_prio_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        inv_valid = 1'b0;
        check_val("inv_prio_mem3", 32'(mem[3]), 32'd0);
        check_val("inv_prio_ready2", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        wait_resp(lat);
        check_val("inv_prio_lat", 32'(lat), 32'd2);
        check_val("inv_prio_hit", 32'(resp_hit), 32'd1);
        @(negedge clock);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
